dsp_dual_mac: RTL and testbench

DSP_DUAL_MAC -- requirements
Module: dsp_dual_mac

---
 rtl/dsp_dual_mac.sv | 176 +++++++++++++++++
 tb/tb_dsp_dual_mac.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_dual_mac.sv
// dsp_dual_mac -- two-lane multiply-accumulate sharing one unsigned operand.
//
// Lane AC accumulates a*c, lane BC accumulates b*c. Samples are framed by
// first/last; a completed sum is presented on ac/bc/ovf with a one-cycle
// valid_out pulse, three cycles after the sample carrying last.
//
// Pipeline: S1 input capture -> S2 exact products -> S3 accumulate/output.
//
// Optional build macro: DSP_DUAL_MAC_SAT_EN
//   defined   : overflowing accumulation clamps to the signed ACC_W limits
//   undefined : accumulation wraps modulo 2^ACC_W
// ovf reports overflow identically in both builds.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   sample valid (first/last/a/b/c ignored when 0)
//   first      in   sample starts a new sum
//   last       in   sample ends the current sum
//   a, b       in   [A_W]   signed operands for lanes AC and BC
//   c          in   [C_W]   unsigned operand shared by both lanes
//   ac, bc     out  [ACC_W] signed sums of the last completed sum
//   valid_out  out  one-cycle pulse when ac/bc/ovf update
//   ovf        out  overflow in either lane during the presented sum
//
// ACC_W must be at least A_W+C_W+1 so a single product always fits.

module dsp_dual_mac #(
    parameter int A_W   = 8,
    parameter int C_W   = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             first,
    input  logic             last,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    output logic [ACC_W-1:0] ac,
    output logic [ACC_W-1:0] bc,
    output logic             valid_out,
    output logic             ovf
);

    localparam int P_W = A_W + C_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Valid shift: [1] = S1 holds a sample, [2] = S2 holds a product.
    logic [2:1] vld_pipe;

    // S1
    logic           s1_first, s1_last;
    logic [A_W-1:0] s1_a, s1_b;
    logic [C_W-1:0] s1_c;

    // S2
    logic                  s2_first, s2_last;
    logic signed [P_W-1:0] s2_pa, s2_pb;

    // S3 running state
    logic signed [ACC_W-1:0] acc_a, acc_b;
    logic                    acc_ovf;

    // Products: c is zero-extended so the shared operand stays unsigned.
    logic signed [P_W-1:0] prod_a, prod_b;
    always_comb begin
        prod_a = P_W'($signed(s1_a)) * P_W'($signed({1'b0, s1_c}));
        prod_b = P_W'($signed(s1_b)) * P_W'($signed({1'b0, s1_c}));
    end

    // One lane accumulate step. Returns {overflow, new_acc}. A load (first)
    // can never overflow because a product always fits in ACC_W.
    function automatic logic [ACC_W:0] lane_step(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [P_W-1:0]   prod,
        input logic                    load
    );
        logic signed [ACC_W-1:0] pe, sum;
        logic                    ov;
        pe  = ACC_W'(prod);
        sum = acc + pe;
        ov  = 1'b0;
        if (load) begin
            sum = pe;
        end else begin
            // Signed overflow: operands agree in sign, result does not.
            ov = (acc[ACC_W-1] == pe[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef DSP_DUAL_MAC_SAT_EN
            if (ov) sum = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
        end
        return {ov, sum};
    endfunction

    logic [ACC_W:0]          step_a, step_b;
    logic signed [ACC_W-1:0] nxt_a, nxt_b;
    logic                    nxt_ovf;
    always_comb begin
        step_a  = lane_step(acc_a, s2_pa, s2_first);
        step_b  = lane_step(acc_b, s2_pb, s2_first);
        nxt_a   = step_a[ACC_W-1:0];
        nxt_b   = step_b[ACC_W-1:0];
        // Sticky within a sum; a first sample starts clean.
        nxt_ovf = (acc_ovf & ~s2_first) | step_a[ACC_W] | step_b[ACC_W];
    end

    // S1: capture. en=0 leaves a bubble; control bits are qualified by en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_c        <= '0;
        end else begin
            vld_pipe[1] <= en;
            s1_first    <= en & first;
            s1_last     <= en & last;
            if (en) begin
                s1_a <= a;
                s1_b <= b;
                s1_c <= c;
            end
        end
    end

    // S2: products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            s2_first    <= 1'b0;
            s2_last     <= 1'b0;
            s2_pa       <= '0;
            s2_pb       <= '0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            s2_first    <= s1_first;
            s2_last     <= s1_last;
            if (vld_pipe[1]) begin
                s2_pa <= prod_a;
                s2_pb <= prod_b;
            end
        end
    end

    // S3: accumulate, and publish on last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a     <= '0;
            acc_b     <= '0;
            acc_ovf   <= 1'b0;
            ac        <= '0;
            bc        <= '0;
            ovf       <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= vld_pipe[2] & s2_last;
            if (vld_pipe[2]) begin
                acc_a   <= nxt_a;
                acc_b   <= nxt_b;
                acc_ovf <= nxt_ovf;
                if (s2_last) begin
                    ac  <= nxt_a;
                    bc  <= nxt_b;
                    ovf <= nxt_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_dual_mac.sv
// Directed bench for dsp_dual_mac. Two instances share the input stimulus:
// the default 24-bit build and a 17-bit accumulator build for overflow cases.
module tb_dsp_dual_mac;

    logic clk = 1'b0;
    logic rst_n, en, first, last;
    logic [7:0] a, b, c;

    logic signed [23:0] ac, bc;
    logic               valid_out, ovf;
    logic signed [16:0] ac17, bc17;
    logic               valid17, ovf17;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsp_dual_mac #(.A_W(8), .C_W(8), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .first(first), .last(last),
        .a(a), .b(b), .c(c), .ac(ac), .bc(bc), .valid_out(valid_out), .ovf(ovf)
    );

    dsp_dual_mac #(.A_W(8), .C_W(8), .ACC_W(17)) dut17 (
        .clk(clk), .rst_n(rst_n), .en(en), .first(first), .last(last),
        .a(a), .b(b), .c(c), .ac(ac17), .bc(bc17), .valid_out(valid17), .ovf(ovf17)
    );

    // Drive one cycle of inputs, clock it in, settle 1 time unit after the edge.
    task automatic step(input logic e, input logic f, input logic l,
                        input int av, input int bv, input int cv);
        int ta, tb, tc;
        ta = av; tb = bv; tc = cv;
        en = e; first = f; last = l;
        a = ta[7:0]; b = tb[7:0]; c = tc[7:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        total++; if (ac !== 24'sd0) begin bad++; $display("FAIL reset_ac got=%0d exp=0", ac); end
        total++; if (bc !== 24'sd0) begin bad++; $display("FAIL reset_bc got=%0d exp=0", bc); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rst_n = 1'b1;
    endtask

    // a=-3, b=5, c=200 single-term sum
    task automatic test_single();
        step(1'b1, 1'b1, 1'b1, -3, 5, 200);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_early1 got=%b exp=0", valid_out); end
        idle();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_early2 got=%b exp=0", valid_out); end
        idle();
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", valid_out); end
        total++; if (ac !== -600) begin bad++; $display("FAIL single_ac got=%0d exp=-600", ac); end
        total++; if (bc !== 1000) begin bad++; $display("FAIL single_bc got=%0d exp=1000", bc); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b exp=0", ovf); end
        idle();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", valid_out); end
        total++; if (ac !== -600) begin bad++; $display("FAIL single_hold got=%0d exp=-600", ac); end
    endtask

    // Four extreme samples with a bubble between the second and third
    task automatic test_bubble();
        int pulses;
        pulses = 0;
        step(1'b1, 1'b1, 1'b0, -128, 127, 255); pulses += int'(valid_out);
        step(1'b1, 1'b0, 1'b0, -128, 127, 255); pulses += int'(valid_out);
        step(1'b0, 1'b1, 1'b1,   55,  66,  77); pulses += int'(valid_out);
        step(1'b1, 1'b0, 1'b0, -128, 127, 255); pulses += int'(valid_out);
        step(1'b1, 1'b0, 1'b1, -128, 127, 255); pulses += int'(valid_out);
        idle(); pulses += int'(valid_out);
        idle();
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bubble_valid got=%b exp=1", valid_out); end
        total++; if (ac !== -130560) begin bad++; $display("FAIL bubble_ac got=%0d exp=-130560", ac); end
        total++; if (bc !== 129540) begin bad++; $display("FAIL bubble_bc got=%0d exp=129540", bc); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bubble_ovf got=%b exp=0", ovf); end
        for (int i = 0; i < 3; i++) begin idle(); pulses += int'(valid_out); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL bubble_extra_pulses got=%0d exp=0", pulses); end
    endtask

    // Three consecutive single-term sums, results on three consecutive cycles
    task automatic test_back_to_back();
        int exp_a[3] = '{3, -4, 1785};
        int exp_b[3] = '{6, -8, 0};
        step(1'b1, 1'b1, 1'b1,  1,  2,   3);
        step(1'b1, 1'b1, 1'b1, -1, -2,   4);
        step(1'b1, 1'b1, 1'b1,  7,  0, 255);
        for (int i = 0; i < 3; i++) begin
            total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, valid_out); end
            total++; if (ac !== exp_a[i]) begin bad++; $display("FAIL b2b_ac[%0d] got=%0d exp=%0d", i, ac, exp_a[i]); end
            total++; if (bc !== exp_b[i]) begin bad++; $display("FAIL b2b_bc[%0d] got=%0d exp=%0d", i, bc, exp_b[i]); end
            idle();
        end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", valid_out); end
    endtask

    // Three a=-128,c=255 terms overflow the 17-bit accumulator; then a new
    // sum with first=1 clears ovf.
    task automatic test_overflow();
        int exp17;
`ifdef DSP_DUAL_MAC_SAT_EN
        exp17 = -65536;
`else
        exp17 = 33152;
`endif
        step(1'b1, 1'b1, 1'b0, -128, 0, 255);
        step(1'b1, 1'b0, 1'b0, -128, 0, 255);
        step(1'b1, 1'b0, 1'b1, -128, 0, 255);
        idle();
        idle();
        total++; if (valid17 !== 1'b1) begin bad++; $display("FAIL ovf17_valid got=%b exp=1", valid17); end
        total++; if (ovf17 !== 1'b1) begin bad++; $display("FAIL ovf17_flag got=%b exp=1", ovf17); end
        total++; if (ac17 !== exp17) begin bad++; $display("FAIL ovf17_ac got=%0d exp=%0d", ac17, exp17); end
        total++; if (bc17 !== 0) begin bad++; $display("FAIL ovf17_bc got=%0d exp=0", bc17); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf24_flag got=%b exp=0", ovf); end
        total++; if (ac !== -97920) begin bad++; $display("FAIL ovf24_ac got=%0d exp=-97920", ac); end
        step(1'b1, 1'b1, 1'b1, 1, 1, 1);
        idle();
        idle();
        total++; if (ovf17 !== 1'b0) begin bad++; $display("FAIL ovf17_clear got=%b exp=0", ovf17); end
        total++; if (ac17 !== 1) begin bad++; $display("FAIL ovf17_next_ac got=%0d exp=1", ac17); end
    endtask

    // Reset in the middle of a sum, then a fresh single-term sum right away
    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b0, 9, 9, 9);
        step(1'b1, 1'b0, 1'b0, 9, 9, 9);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ac !== 24'sd0 || bc !== 24'sd0) begin bad++; $display("FAIL rstmid_acbc got=%0d/%0d exp=0/0", ac, bc); end
        total++; if (valid_out !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", valid_out, ovf); end
        total++; if (ac17 !== 17'sd0) begin bad++; $display("FAIL rstmid_ac17 got=%0d exp=0", ac17); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 2, 3, 10);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_ghost1 got=%b exp=0", valid_out); end
        idle();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_ghost2 got=%b exp=0", valid_out); end
        idle();
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL rstmid_valid got=%b exp=1", valid_out); end
        total++; if (ac !== 20) begin bad++; $display("FAIL rstmid_ac got=%0d exp=20", ac); end
        total++; if (bc !== 30) begin bad++; $display("FAIL rstmid_bc got=%0d exp=30", bc); end
    endtask

    // en=0 with first=last=1 and changing data must do nothing
    task automatic test_en_idle();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 17 * i - 60, 100 - 13 * i, 25 * i + 3);
            pulses += int'(valid_out);
        end
        for (int i = 0; i < 3; i++) begin idle(); pulses += int'(valid_out); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
        total++; if (ac !== 20) begin bad++; $display("FAIL idle_ac got=%0d exp=20", ac); end
        total++; if (bc !== 30) begin bad++; $display("FAIL idle_bc got=%0d exp=30", bc); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; first = 1'b0; last = 1'b0;
        a = '0; b = '0; c = '0;
        test_reset();
        test_single();
        test_bubble();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_en_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
